// File: rtl/jtag_tap_controller_pkg.sv
// jtag_tap_controller_pkg: TAP state encoding and column decode shared by the TAP slice
package jtag_tap_controller_pkg;
    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    function automatic logic is_ir_col(tap_state_e s);
        return s inside {SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR};
    endfunction
endpackage

// File: rtl/jtag_tap_controller_if.sv
// jtag_tap_controller_if: TMS in, state and IR/DR control strobes out
interface jtag_tap_controller_if #(parameter int STATE_W = 4);
    logic               TMS;
    logic [STATE_W-1:0] TapState;
    logic               ShiftIR;
    logic               ClockIR;
    logic               UpdateIR;
    logic               ShiftDR;
    logic               ClockDR;
    logic               UpdateDR;
    logic               RstIR;
    logic               Select;
    logic               Enable;
    modport master (
        output TMS,
        input  TapState, ShiftIR, ClockIR, UpdateIR, ShiftDR, ClockDR, UpdateDR, RstIR, Select, Enable
    );
    modport slave (
        input  TMS,
        output TapState, ShiftIR, ClockIR, UpdateIR, ShiftDR, ClockDR, UpdateDR, RstIR, Select, Enable
    );
endinterface

// File: rtl/jtag_tap_controller_clock_gate.sv
// jtag_tap_controller_clock_gate: falling-edge enable flop, optionally ANDed with the clock
module jtag_tap_controller_clock_gate #(
    parameter bit GATED = 1
) (
    input  logic clk,
    input  logic en,
    output logic gclk
);
    logic en_q;
    always_ff @(negedge clk) en_q <= en;
    assign gclk = GATED ? clk & en_q : en_q;
endmodule

// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller: IEEE 1149.1 TAP state machine driving IR/DR control strobes
module jtag_tap_controller
    import jtag_tap_controller_pkg::*;
#(
    parameter int STATE_W      = 4,
    parameter bit GATED_CLOCKS = 1
) (
    input  logic                  TCK,
    input  logic                  Reset,
    jtag_tap_controller_if.slave  tap
);
    tap_state_e state, state_nxt;
    logic clk_en_ir, clk_en_dr;
    always_ff @(posedge TCK) state <= Reset ? TLR : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            TLR:                 state_nxt = tap.TMS ? TLR    : RTI;
            RTI, UPD_DR, UPD_IR: state_nxt = tap.TMS ? SEL_DR : RTI;
            SEL_DR:              state_nxt = tap.TMS ? SEL_IR : CAP_DR;
            SEL_IR:              state_nxt = tap.TMS ? TLR    : CAP_IR;
            CAP_DR, SH_DR:       state_nxt = tap.TMS ? EX1_DR : SH_DR;
            EX1_DR:              state_nxt = tap.TMS ? UPD_DR : PAUSE_DR;
            PAUSE_DR:            state_nxt = tap.TMS ? EX2_DR : PAUSE_DR;
            EX2_DR:              state_nxt = tap.TMS ? UPD_DR : SH_DR;
            CAP_IR, SH_IR:       state_nxt = tap.TMS ? EX1_IR : SH_IR;
            EX1_IR:              state_nxt = tap.TMS ? UPD_IR : PAUSE_IR;
            PAUSE_IR:            state_nxt = tap.TMS ? EX2_IR : PAUSE_IR;
            EX2_IR:              state_nxt = tap.TMS ? UPD_IR : SH_IR;
            default:             state_nxt = TLR;
        endcase
    end
    always_comb begin
        tap.TapState = STATE_W'(state);
        tap.ShiftIR  = state == SH_IR;
        tap.ShiftDR  = state == SH_DR;
        tap.Select   = is_ir_col(state);
        clk_en_ir    = state inside {CAP_IR, SH_IR};
        clk_en_dr    = state inside {CAP_DR, SH_DR};
    end
    // strobes settle while TCK is low so IR/DR chains see them stable at the next rising edge
    always_ff @(negedge TCK) begin
        tap.UpdateIR <= state == UPD_IR;
        tap.UpdateDR <= state == UPD_DR;
        tap.RstIR    <= state == TLR;
        tap.Enable   <= state inside {SH_IR, SH_DR};
    end
    jtag_tap_controller_clock_gate #(.GATED(GATED_CLOCKS)) u_gate_ir (
        .clk  (TCK),
        .en   (clk_en_ir),
        .gclk (tap.ClockIR)
    );
    jtag_tap_controller_clock_gate #(.GATED(GATED_CLOCKS)) u_gate_dr (
        .clk  (TCK),
        .en   (clk_en_dr),
        .gclk (tap.ClockDR)
    );
endmodule
